// File: rtl/inst_mem_dual.sv
// Dual-issue instruction memory: two consecutive words per fetch, one-cycle latency,
// with a runtime sequential load port. Define INST_MEM_WRAP_EN for circular fetch at the last word.
module inst_mem_dual #(
    parameter int unsigned DEPTH    = 256,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fetch_req,
    input  logic [31:0]               fetch_addr,
    input  logic                      stall,
    output logic                      fetch_ready,
    output logic [31:0]               inst0,
    output logic [31:0]               inst1,
    output logic                      inst0_valid,
    output logic                      inst1_valid,
    output logic                      misalign,
    output logic                      oob,
    input  logic                      load_start,
    input  logic                      load_we,
    input  logic [31:0]               load_data,
    input  logic                      load_done,
    output logic                      load_busy,
    output logic [$clog2(DEPTH):0]    load_count,
    output logic                      load_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrMax = (AW + 1)'(DEPTH);

    typedef enum logic [0:0] {StRun, StLoad} state_e;

    state_e      state_q, state_d;
    logic [AW:0] ptr_q, ptr_d;
    logic        ovf_q, ovf_d;
    logic        mem_we;

    logic [31:0] mem [DEPTH];

    logic [31:0] inst0_q, inst0_d, inst1_q, inst1_d;
    logic        v0_q, v0_d, v1_q, v1_d;
    logic        mis_q, mis_d, oob_q, oob_d;

    logic [AW-1:0] idx, idx_nxt;
    logic          is_oob, is_mis, accept;
    logic [31:0]   rd0, rd1;

    always_comb begin
        idx     = fetch_addr[AW+1:2];
        idx_nxt = idx + AW'(1);
        is_oob  = |fetch_addr[31:AW+2];
        is_mis  = |fetch_addr[1:0];
        accept  = fetch_req && (state_q == StRun) && !stall;
        rd0     = mem[idx];
        rd1     = mem[idx_nxt];
    end

    // Load-port FSM; a restart in LOAD takes priority over both write and done.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        mem_we  = 1'b0;
        case (state_q)
            StRun: begin
                if (load_start) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            StLoad: begin
                if (load_start) begin
                    ptr_d = '0;
                    ovf_d = 1'b0;
                end else begin
                    if (load_we) begin
                        if (ptr_q < PtrMax) begin
                            mem_we = 1'b1;
                            ptr_d  = ptr_q + (AW + 1)'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (load_done) begin
                        state_d = StRun;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        inst0_d = inst0_q;
        inst1_d = inst1_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        mis_d   = 1'b0;
        oob_d   = oob_q;
        if (load_start) begin
            v0_d  = 1'b0;
            v1_d  = 1'b0;
            oob_d = 1'b0;
        end else if (stall) begin
            // hold everything; misalign is a pulse and already cleared above
        end else if (accept) begin
            if (is_mis || is_oob) begin
                inst0_d = NOP_WORD;
                inst1_d = NOP_WORD;
                v0_d    = 1'b0;
                v1_d    = 1'b0;
                mis_d   = is_mis;
                oob_d   = is_oob;
            end else begin
                inst0_d = rd0;
                v0_d    = 1'b1;
                oob_d   = 1'b0;
`ifdef INST_MEM_WRAP_EN
                // idx_nxt wraps to 0 at the last word
                inst1_d = rd1;
                v1_d    = 1'b1;
`else
                if (idx == AW'(DEPTH - 1)) begin
                    inst1_d = NOP_WORD;
                    v1_d    = 1'b0;
                end else begin
                    inst1_d = rd1;
                    v1_d    = 1'b1;
                end
`endif
            end
        end else begin
            v0_d  = 1'b0;
            v1_d  = 1'b0;
            oob_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            inst0_q <= NOP_WORD;
            inst1_q <= NOP_WORD;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            mis_q   <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            inst0_q <= inst0_d;
            inst1_q <= inst1_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            mis_q   <= mis_d;
            oob_q   <= oob_d;
        end
    end

    // Array is deliberately not reset so loaded programs survive a core reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q[AW-1:0]] <= load_data;
        end
    end

    assign fetch_ready = (state_q == StRun);
    assign load_busy   = (state_q == StLoad);
    assign load_count  = ptr_q;
    assign load_ovf    = ovf_q;
    assign inst0       = inst0_q;
    assign inst1       = inst1_q;
    assign inst0_valid = v0_q;
    assign inst1_valid = v1_q;
    assign misalign    = mis_q;
    assign oob         = oob_q;

endmodule
